// File: rtl/ram_arbiter_o9.sv
// Two-requester (instruction fetch / data load-store) arbiter in front of the
// single-port O9 word RAM; one access per three cycles, RAM read data registered.
module ram_arbiter_o9 #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [ADDR_W-1:0] LP_LIMIT = ADDR_W'(MEM_WORDS);

    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return (addr < LP_LIMIT);
    endfunction

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;

    logic              r_if_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_err;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_err;

    logic              w_any_req;
    logic              w_grant_d;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_mem_wren;

    // Winner selection: a lone requester wins; on conflict the one not granted last wins.
    always_comb begin
        w_any_req = if_req | d_req;
        if (d_req && (!if_req || (r_last_grant == OWN_IF))) begin
            w_grant_d = 1'b1;
        end else begin
            w_grant_d = 1'b0;
        end
    end

    // Access-cycle decode: range check, write enable and read data capture value.
    always_comb begin
        w_in_range = f_in_range(r_addr);
        if ((r_state == ST_ACCESS) && r_we && w_in_range) begin
            w_mem_wren = 1'b1;
        end else begin
            w_mem_wren = 1'b0;
        end
        if (!r_we && w_in_range) begin
            w_rd_data = mem_q;
        end else begin
            w_rd_data = {DATA_W{1'b0}};
        end
    end

    // Sequencer and access registers; only the IDLE state samples requests.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_D;
            r_last_grant <= OWN_D;
            r_addr       <= {ADDR_W{1'b0}};
            r_we         <= 1'b0;
            r_wdata      <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant_d;
                        r_last_grant <= w_grant_d;
                        r_state      <= ST_ACCESS;
                        if (w_grant_d) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                        end else begin
                            // Fetches are read-only; write data is left as last latched.
                            r_addr  <= if_addr;
                            r_we    <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response registers: ack pulse during RESP, data/err held until the next ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_if_ack   <= 1'b0;
            r_if_rdata <= {DATA_W{1'b0}};
            r_if_err   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_d_rdata  <= {DATA_W{1'b0}};
            r_d_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCESS: begin
                    if (r_owner == OWN_D) begin
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= w_rd_data;
                        r_d_err   <= ~w_in_range;
                        r_if_ack  <= 1'b0;
                    end else begin
                        r_if_ack   <= 1'b1;
                        r_if_rdata <= w_rd_data;
                        r_if_err   <= ~w_in_range;
                        r_d_ack    <= 1'b0;
                    end
                end
                default: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign if_err      = r_if_err;
    assign d_ack       = r_d_ack;
    assign d_rdata     = r_d_rdata;
    assign d_err       = r_d_err;
    assign mem_address = r_addr;
    assign mem_data    = r_wdata;
    assign mem_wren    = w_mem_wren;

endmodule

// File: tb/tb_ram_arbiter_o9.sv
// Self-checking bench for ram_arbiter_o9: behavioural RAM, per-port response
// scoreboards, a data-port vector table and hand-written multi-cycle sequences.
module tb_ram_arbiter_o9;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [15:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    ram_arbiter_o9 dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Behavioural 1024-word RAM: word i preloads to A5000000+i.
    logic [31:0] ram [0:1023];
    logic        preload;
    assign mem_q = (mem_address < 16'd1024) ? ram[mem_address[9:0]] : 32'h0;
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 + 32'(i);
        end else if (mem_wren && (mem_address < 16'd1024)) begin
            ram[mem_address[9:0]] <= mem_data;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t q_if[$];
    resp_t q_d[$];

    int n_checks = 0;
    int n_fail   = 0;
    int wren_cnt = 0;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count write pulses and score every ack against the port's queue.
    always @(negedge clock) begin
        resp_t e;
        if (mem_wren === 1'b1) begin
            wren_cnt++;
            wr_addr = mem_address;
            wr_data = mem_data;
        end
        if (if_ack === 1'b1) begin
            if (q_if.size() == 0) begin
                check("if_ack_unexpected", 32'(if_ack), 32'd0);
            end else begin
                e = q_if.pop_front();
                check("if_rdata", if_rdata, e.rdata);
                check("if_err", 32'(if_err), 32'(e.err));
            end
        end
        if (d_ack === 1'b1) begin
            if (q_d.size() == 0) begin
                check("d_ack_unexpected", 32'(d_ack), 32'd0);
            end else begin
                e = q_d.pop_front();
                check("d_rdata", d_rdata, e.rdata);
                check("d_err", 32'(d_err), 32'(e.err));
            end
        end
    end

    // Data transaction; entered and left just after a rising edge with the arbiter idle.
    task automatic d_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_wren);
        int    w0;
        int    lat;
        resp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        q_d.push_back(e);
        w0 = wren_cnt;
        lat = 0;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clock);
            if (d_ack === 1'b1) lat = n;
        end
        check("d_latency", 32'(lat), 32'd3);
        @(posedge clock); #1;
        d_req = 1'b0; d_we = 1'b0;
        check("d_ack_one_cycle", 32'(d_ack), 32'd0);
        check("d_rdata_hold", d_rdata, exp_rd);
        check("wren_pulses", 32'(wren_cnt - w0), 32'(exp_wren));
        if (exp_wren == 1) begin
            check("wren_addr", 32'(wr_addr), 32'(addr));
            check("wren_data", wr_data, wdata);
        end
        @(posedge clock); #1;
    endtask

    task automatic if_fetch(input logic [15:0] addr, input logic [31:0] exp_rd);
        int    lat;
        resp_t e;
        e.rdata = exp_rd;
        e.err   = 1'b0;
        q_if.push_back(e);
        lat = 0;
        if_req = 1'b1; if_addr = addr;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clock);
            if (if_ack === 1'b1) lat = n;
        end
        check("if_latency", 32'(lat), 32'd3);
        @(posedge clock); #1;
        if_req = 1'b0;
        check("if_rdata_hold", if_rdata, exp_rd);
        @(posedge clock); #1;
    endtask

    // Simultaneous fetch of word 0 and data read of word 1; checks ack positions.
    task automatic conflict(input string name, input int exp_if_at, input int exp_d_at);
        int    if_at;
        int    d_at;
        resp_t e;
        e.err = 1'b0;
        e.rdata = 32'hA500_0000; q_if.push_back(e);
        e.rdata = 32'hA500_0001; q_d.push_back(e);
        if_at = 0; d_at = 0;
        if_req = 1'b1; if_addr = 16'd0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd1;
        for (int n = 1; n <= 12 && (if_req || d_req); n++) begin
            @(negedge clock);
            if (if_ack === 1'b1) if_at = n;
            if (d_ack === 1'b1) d_at = n;
            if (if_at == n || d_at == n) begin
                @(posedge clock); #1;
                if (if_at == n) if_req = 1'b0;
                if (d_at == n) d_req = 1'b0;
            end
        end
        check({name, "_if_at"}, 32'(if_at), 32'(exp_if_at));
        check({name, "_d_at"}, 32'(d_at), 32'(exp_d_at));
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wren;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int at[4];
        int k;
        resp_t e;

        vecs[0] = '{1'b1, 16'd5,      32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1};
        vecs[1] = '{1'b0, 16'd5,      32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[2] = '{1'b1, 16'd1024,   32'h1234_5678, 32'h0000_0000, 1'b1, 0};
        vecs[3] = '{1'b0, 16'd0,      32'h0000_0000, 32'hA500_0000, 1'b0, 0};
        vecs[4] = '{1'b1, 16'd1023,   32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1};
        vecs[5] = '{1'b0, 16'd1023,   32'h0000_0000, 32'hCAFE_F00D, 1'b0, 0};
        vecs[6] = '{1'b0, 16'd1024,   32'h0000_0000, 32'h0000_0000, 1'b1, 0};
        vecs[7] = '{1'b0, 16'hFFFF,   32'h0000_0000, 32'h0000_0000, 1'b1, 0};
        vecs[8] = '{1'b1, 16'hFFFF,   32'h0BAD_F00D, 32'h0000_0000, 1'b1, 0};
        vecs[9] = '{1'b0, 16'd5,      32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0};

        if_req = 1'b0; if_addr = 16'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'd0; d_wdata = 32'd0;
        reset = 1'b1; preload = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        preload = 1'b0;
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_if_err", 32'(if_err), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_d_err", 32'(d_err), 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_mem_wren", 32'(mem_wren), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // Data-port vectors: write/read, out-of-range and boundary addresses.
        for (int i = 0; i < 10; i++) begin
            d_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_wren);
        end

        // Conflicts after reset: IF first twice (last grant DATA), then D first after an IF grant.
        do_reset();
        conflict("conf1", 3, 6);
        conflict("conf2", 3, 6);
        if_fetch(16'd2, 32'hA500_0002);
        conflict("conf3", 6, 3);

        // Reset during the ACCESS cycle of a write to word 7.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'd7; d_wdata = 32'h7777_7777;
        @(negedge clock);
        @(negedge clock);
        check("t5_wren_in_access", 32'(mem_wren), 32'd1);
        check("t5_addr_in_access", 32'(mem_address), 32'd7);
        #1 reset = 1'b1;
        #1;
        check("t5_wren_drop", 32'(mem_wren), 32'd0);
        check("t5_no_ack", 32'(d_ack), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clock); #1;
        check("t5_no_ack_later", 32'(d_ack), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        d_txn(1'b0, 16'd3, 32'd0, 32'hA500_0003, 1'b0, 0);

        // Held fetch request, address advanced in the cycle after each ack.
        for (int i = 0; i < 4; i++) begin
            e.rdata = 32'hA500_0000 + 32'(i);
            e.err = 1'b0;
            q_if.push_back(e);
        end
        k = 0;
        if_req = 1'b1; if_addr = 16'd0;
        for (int n = 1; n <= 20 && k < 4; n++) begin
            @(negedge clock);
            if (if_ack === 1'b1) begin
                at[k] = n;
                k++;
                @(posedge clock); #1;
                if (k < 4) if_addr = 16'(k);
                else if_req = 1'b0;
            end
        end
        check("t6_ack_count", 32'(k), 32'd4);
        if (k == 4) begin
            check("t6_first_at", 32'(at[0]), 32'd3);
            for (int i = 1; i < 4; i++) check("t6_spacing", 32'(at[i] - at[i-1]), 32'd3);
        end
        repeat (6) @(posedge clock);
        #1;

        check("if_queue_drained", 32'(q_if.size()), 32'd0);
        check("d_queue_drained", 32'(q_d.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
